serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder computing a+b+cin one bit per clock, LSB
// first, through a single shared 1-bit full-adder cell. A three-state FSM
// (IDLE -> RUN -> DONE) sequences each operation. busy, done, sum, cout and
// overflow are all registered.

// One-bit full-adder cell shared by every bit position of the serial adder.
module fullAdder (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = x ^ y ^ cin;
   assign cout = (x & y) | (x & cin) | (y & cin);
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] a_sh_r;
   logic [WIDTH-1:0] b_sh_r;
   // Partial sum keeps only WIDTH-1 bits. The last bit comes straight from
   // the cell on the final RUN edge, so the result is never shifted out.
   logic [WIDTH-2:0] psum_r;
   logic             carry_r;
   logic [CW-1:0]    cnt_r;

   logic             fa_sum_s;
   logic             fa_cout_s;
   logic [WIDTH-1:0] psum_next_s;

   fullAdder u_fa (
      .x    (a_sh_r[0]),
      .y    (b_sh_r[0]),
      .cin  (carry_r),
      .sum  (fa_sum_s),
      .cout (fa_cout_s)
   );

   // New cell sum enters at the MSB, so after WIDTH edges bit 0 sits at the LSB.
   assign psum_next_s = {fa_sum_s, psum_r};

   // Sequencing FSM: accepts operands, steps one bit per RUN edge, publishes the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         a_sh_r   <= '0;
         b_sh_r   <= '0;
         psum_r   <= '0;
         carry_r  <= 1'b0;
         cnt_r    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh_r  <= a;
                  b_sh_r  <= b;
                  carry_r <= cin;
                  psum_r  <= '0;
                  cnt_r   <= '0;
                  busy    <= 1'b1;
                  state_r <= RUN;
               end else begin
                  busy    <= 1'b0;
                  state_r <= IDLE;
               end
            end
            RUN: begin
               a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
               b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
               psum_r  <= psum_next_s[WIDTH-1:1];
               carry_r <= fa_cout_s;
               cnt_r   <= cnt_r + CNT_ONE;
               if (cnt_r == LAST_CNT) begin
                  // carry_r still holds the carry into the MSB on this edge.
                  sum      <= psum_next_s;
                  cout     <= fa_cout_s;
                  overflow <= carry_r ^ fa_cout_s;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state_r  <= DONE;
               end else begin
                  busy    <= 1'b1;
                  state_r <= RUN;
               end
            end
            DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
